// File: rtl/uart_stream_checker_pkg.sv
// uart_stream_pkg: shared constants, FSM state types and the expected-byte
// helper for uart_stream_checker and its command sender.
package uart_stream_pkg;

  localparam int         FRAME_LEN    = 32;
  localparam logic [7:0] NEWLINE      = 8'h0A;
  localparam logic [7:0] CMD_TOGGLE   = 8'h53;
  localparam logic [7:0] BASE_DEFAULT = 8'h41;

  typedef enum logic {
    HUNT,
    TRACK
  } chk_state_e;

  typedef enum logic [1:0] {
    C_IDLE,
    C_WAIT,
    C_LOAD,
    C_DRAIN
  } cmd_state_e;

  // Byte expected at frame position idx: BASE+idx for the body, newline last.
  function automatic logic [7:0] expected_byte(input logic [7:0] base,
                                               input logic [4:0] idx);
    if (idx == 5'(FRAME_LEN - 1)) return NEWLINE;
    return base + {3'b000, idx};
  endfunction

endpackage

// File: rtl/uart_stream_checker_if.sv
// uart_stream_checker_if: RX byte stream in, TX command handshake and checker
// status out. master = stimulus/system side, slave = the checker.
interface uart_stream_checker_if #(
  parameter int CNT_W = 16
);
  logic [7:0]       rx_data;
  logic             rx_strobe;
  logic             send_cmd;
  logic             load_ok;
  logic             tx_load;
  logic [7:0]       tx_data;
  logic             cmd_busy;
  logic             locked;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic             err_strobe;

  modport master (
    output rx_data, rx_strobe, send_cmd, load_ok,
    input  tx_load, tx_data, cmd_busy, locked, frame_cnt, err_cnt, err_strobe
  );

  modport slave (
    input  rx_data, rx_strobe, send_cmd, load_ok,
    output tx_load, tx_data, cmd_busy, locked, frame_cnt, err_cnt, err_strobe
  );
endinterface

// File: rtl/uart_stream_checker_cmd_sender.sv
// uart_cmd_sender: issues one TX load of the 'S' toggle command per request,
// waiting for the transmitter to be ready and then for it to go busy again
// so a single request can never produce two sends.
module uart_cmd_sender
  import uart_stream_pkg::*;
(
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       send_cmd,
  input  logic       load_ok,
  output logic       tx_load,
  output logic [7:0] tx_data,
  output logic       cmd_busy
);

  cmd_state_e state_q, state_d;
  logic       tx_load_q;
  logic       cmd_busy_q;

  // Next-state logic; requests arriving outside C_IDLE are dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      C_IDLE:  if (send_cmd) state_d = C_WAIT;
      C_WAIT:  if (load_ok)  state_d = C_LOAD;
      C_LOAD:                state_d = C_DRAIN;
      C_DRAIN: if (!load_ok) state_d = C_IDLE;
      default:               state_d = C_IDLE;
    endcase
  end

  // State and registered outputs, decoded from the next state.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q    <= C_IDLE;
      tx_load_q  <= 1'b0;
      cmd_busy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_load_q  <= (state_d == C_LOAD);
      cmd_busy_q <= (state_d != C_IDLE);
    end
  end

  assign tx_load  = tx_load_q;
  assign cmd_busy = cmd_busy_q;
  assign tx_data  = CMD_TOGGLE;

endmodule

// File: rtl/uart_stream_checker.sv
// uart_stream_checker: tracks the 32-byte BASE+i / newline frame pattern,
// keeps saturating frame and error counters, and owns the 'S' command sender.
// Optional inter-byte timeout enabled by defining UART_STREAM_CHK_TIMEOUT_EN.
module uart_stream_checker
  import uart_stream_pkg::*;
#(
  parameter logic [7:0] BASE           = BASE_DEFAULT,
  parameter int         CNT_W          = 16,
  parameter int         TIMEOUT_CYCLES = 24000
) (
  input logic                  sys_clk,
  input logic                  rst_n,
  uart_stream_checker_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  chk_state_e       state_q, state_d;
  logic [4:0]       idx_q, idx_d;
  logic [CNT_W-1:0] frame_q, frame_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             locked_q;
  logic             err_stb_q;
  logic             frame_done;
  logic             err_hit;
  logic             timeout_hit;

`ifdef UART_STREAM_CHK_TIMEOUT_EN
  localparam int              IDLE_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  logic [IDLE_W-1:0] idle_q, idle_d;

  // A strobe in the firing cycle takes priority over the timeout.
  assign timeout_hit = (state_q == TRACK) && !bus.rx_strobe && (idle_q == IDLE_LAST);

  // Idle counter: counts silent cycles in TRACK, cleared by any byte.
  always_comb begin
    idle_d = idle_q + IDLE_W'(1);
    if (state_q != TRACK || bus.rx_strobe || timeout_hit) idle_d = '0;
  end

  // Idle counter register.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) idle_q <= '0;
    else        idle_q <= idle_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
`endif

  // Checker next state: frame tracking plus counter increments.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    frame_done = 1'b0;
    err_hit    = 1'b0;
    case (state_q)
      HUNT: begin
        if (bus.rx_strobe && bus.rx_data == BASE) begin
          state_d = TRACK;
          idx_d   = 5'd1;
        end
      end
      TRACK: begin
        if (bus.rx_strobe) begin
          if (bus.rx_data == expected_byte(BASE, idx_q)) begin
            if (idx_q == 5'(FRAME_LEN - 1)) begin
              frame_done = 1'b1;
              idx_d      = 5'd0;
            end else begin
              idx_d = idx_q + 5'd1;
            end
          end else begin
            // The offending byte is dropped, not re-checked as a frame start.
            err_hit = 1'b1;
            state_d = HUNT;
            idx_d   = 5'd0;
          end
        end else if (timeout_hit) begin
          err_hit = 1'b1;
          state_d = HUNT;
          idx_d   = 5'd0;
        end
      end
      default: begin
        state_d = HUNT;
        idx_d   = 5'd0;
      end
    endcase

    frame_d = frame_q;
    if (frame_done && frame_q != '1) frame_d = frame_q + CNT_ONE;
    err_d = err_q;
    if (err_hit && err_q != '1) err_d = err_q + CNT_ONE;
  end

  // Checker state, counters and registered status outputs.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q   <= HUNT;
      idx_q     <= 5'd0;
      frame_q   <= '0;
      err_q     <= '0;
      locked_q  <= 1'b0;
      err_stb_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      frame_q   <= frame_d;
      err_q     <= err_d;
      locked_q  <= (state_d == TRACK);
      err_stb_q <= err_hit;
    end
  end

  assign bus.locked     = locked_q;
  assign bus.frame_cnt  = frame_q;
  assign bus.err_cnt    = err_q;
  assign bus.err_strobe = err_stb_q;

  uart_cmd_sender u_cmd (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .send_cmd (bus.send_cmd),
    .load_ok  (bus.load_ok),
    .tx_load  (bus.tx_load),
    .tx_data  (bus.tx_data),
    .cmd_busy (bus.cmd_busy)
  );

endmodule

// File: tb/tb_uart_stream_checker.sv
// tb_uart_stream_checker: table-driven checks on a CNT_W=16 instance, plus
// hand-written sequences for counter saturation (CNT_W=2) and the inter-byte
// timeout (TIMEOUT_CYCLES=100, behaviour depends on UART_STREAM_CHK_TIMEOUT_EN).
module tb_uart_stream_checker;

  logic       sys_clk = 1'b0;
  logic       rst_n   = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_strobe = 1'b0;
  logic       send_cmd  = 1'b0;
  logic       load_ok   = 1'b0;

  int total = 0;
  int bad   = 0;
  int loads = 0;

  always #5 sys_clk = ~sys_clk;

  uart_stream_checker_if #(.CNT_W(16)) bus1 ();
  uart_stream_checker_if #(.CNT_W(2))  bus2 ();
  uart_stream_checker_if #(.CNT_W(16)) bus3 ();

  assign bus1.rx_data = rx_data;  assign bus1.rx_strobe = rx_strobe;
  assign bus1.send_cmd = send_cmd; assign bus1.load_ok = load_ok;
  assign bus2.rx_data = rx_data;  assign bus2.rx_strobe = rx_strobe;
  assign bus2.send_cmd = send_cmd; assign bus2.load_ok = load_ok;
  assign bus3.rx_data = rx_data;  assign bus3.rx_strobe = rx_strobe;
  assign bus3.send_cmd = send_cmd; assign bus3.load_ok = load_ok;

  uart_stream_checker #(.CNT_W(16)) dut1 (.sys_clk(sys_clk), .rst_n(rst_n), .bus(bus1));
  uart_stream_checker #(.CNT_W(2))  dut2 (.sys_clk(sys_clk), .rst_n(rst_n), .bus(bus2));
  uart_stream_checker #(.CNT_W(16), .TIMEOUT_CYCLES(100))
                                    dut3 (.sys_clk(sys_clk), .rst_n(rst_n), .bus(bus3));

  typedef struct {
    logic        rst_n;
    logic        stb;
    logic [7:0]  data;
    logic        cmd;
    logic        lok;
    logic        e_locked;
    logic        e_estb;
    logic        e_tload;
    logic        e_busy;
    logic [15:0] e_frame;
    logic [15:0] e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [7:0] frame_byte(input int i);
    logic [7:0] b;
    b = 8'h41 + 8'(i);
    return (i == 31) ? 8'h0A : b;
  endfunction

  task automatic add(input logic r, input logic stb, input logic [7:0] d,
                     input logic cmd, input logic lok,
                     input logic el, input logic ees, input logic etl, input logic eb,
                     input logic [15:0] ef, input logic [15:0] ee);
    vec_t v;
    v.rst_n = r; v.stb = stb; v.data = d; v.cmd = cmd; v.lok = lok;
    v.e_locked = el; v.e_estb = ees; v.e_tload = etl; v.e_busy = eb;
    v.e_frame = ef; v.e_err = ee;
    tbl.push_back(v);
  endtask

  task automatic add_rst();
    add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0, 0, 0, 0, 16'd0, 16'd0);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs and sample 1 time unit after the edge.
  task automatic drive(input logic r, input logic stb, input logic [7:0] d,
                       input logic cmd, input logic lok);
    rst_n = r; rx_strobe = stb; rx_data = d; send_cmd = cmd; load_ok = lok;
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    // ---------------- table for dut1 ----------------
    add_rst(); add_rst();
    // two clean frames
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 32; i++)
        add(1, 1, frame_byte(i), 0, 0, 1, 0, 0, 0, 16'(f + (i == 31 ? 1 : 0)), 16'd0);
    // 41 42 58: error on 58, then a full frame
    add_rst();
    add(1, 1, 8'h41, 0, 0, 1, 0, 0, 0, 16'd0, 16'd0);
    add(1, 1, 8'h42, 0, 0, 1, 0, 0, 0, 16'd0, 16'd0);
    add(1, 1, 8'h58, 0, 0, 0, 1, 0, 0, 16'd0, 16'd1);
    add(1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 16'd0, 16'd1);
    for (int i = 0; i < 32; i++)
      add(1, 1, frame_byte(i), 0, 0, 1, 0, 0, 0, 16'(i == 31 ? 1 : 0), 16'd1);
    // leading junk, then a frame
    add_rst();
    add(1, 1, 8'h00, 0, 0, 0, 0, 0, 0, 16'd0, 16'd0);
    add(1, 1, 8'h7F, 0, 0, 0, 0, 0, 0, 16'd0, 16'd0);
    for (int i = 0; i < 32; i++)
      add(1, 1, frame_byte(i), 0, 0, 1, 0, 0, 0, 16'(i == 31 ? 1 : 0), 16'd0);
    // 41 41 42: second 41 errors and is not a new start, so 42 is ignored
    add(1, 1, 8'h41, 0, 0, 1, 0, 0, 0, 16'd1, 16'd0);
    add(1, 1, 8'h41, 0, 0, 0, 1, 0, 0, 16'd1, 16'd1);
    add(1, 1, 8'h42, 0, 0, 0, 0, 0, 0, 16'd1, 16'd1);
    // bad terminator at idx 31
    for (int i = 0; i < 31; i++)
      add(1, 1, frame_byte(i), 0, 0, 1, 0, 0, 0, 16'd1, 16'd1);
    add(1, 1, 8'h60, 0, 0, 0, 1, 0, 0, 16'd1, 16'd2);
    add(1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 16'd1, 16'd2);
    // command with a simultaneous frame start; repeats while busy are ignored
    add_rst();
    add(1, 1, 8'h41, 1, 1, 1, 0, 0, 1, 16'd0, 16'd0);
    add(1, 1, 8'h42, 0, 1, 1, 0, 1, 1, 16'd0, 16'd0);
    add(1, 0, 8'h00, 1, 1, 1, 0, 0, 1, 16'd0, 16'd0);
    add(1, 0, 8'h00, 1, 1, 1, 0, 0, 1, 16'd0, 16'd0);
    add(1, 0, 8'h00, 0, 0, 1, 0, 0, 0, 16'd0, 16'd0);
    add(1, 0, 8'h00, 0, 1, 1, 0, 0, 0, 16'd0, 16'd0);
    // reset mid-frame and mid-command (waiting), with load_ok high after
    add(1, 0, 8'h00, 1, 0, 1, 0, 0, 1, 16'd0, 16'd0);
    add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 0, 0, 0, 0, 16'd0, 16'd0);
    add(1, 0, 8'h00, 0, 1, 0, 0, 0, 0, 16'd0, 16'd0);
    add(1, 0, 8'h00, 0, 1, 0, 0, 0, 0, 16'd0, 16'd0);

    foreach (tbl[k]) begin
      drive(tbl[k].rst_n, tbl[k].stb, tbl[k].data, tbl[k].cmd, tbl[k].lok);
      if (bus1.tx_load) loads++;
      chk($sformatf("vec%0d {lk,es,tl,bz,txd,frm,err}", k),
          64'({bus1.locked, bus1.err_strobe, bus1.tx_load, bus1.cmd_busy,
               bus1.tx_data, bus1.frame_cnt, bus1.err_cnt}),
          64'({tbl[k].e_locked, tbl[k].e_estb, tbl[k].e_tload, tbl[k].e_busy,
               8'h53, tbl[k].e_frame, tbl[k].e_err}));
    end
    chk("total_tx_loads", 64'(loads), 64'd1);

    // ---------------- CNT_W=2 saturation on dut2 ----------------
    drive(0, 0, 8'h00, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      for (int i = 0; i < 32; i++) drive(1, 1, frame_byte(i), 0, 0);
      chk($sformatf("sat_frame_%0d", k), 64'(bus2.frame_cnt), 64'((k < 3) ? k : 3));
    end
    drive(1, 0, 8'h00, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      drive(1, 1, 8'h41, 0, 0);
      drive(1, 1, 8'h00, 0, 0);
      chk($sformatf("sat_err_%0d", k), 64'(bus2.err_cnt), 64'((k < 3) ? k : 3));
    end

    // ---------------- timeout on dut3 ----------------
    drive(0, 0, 8'h00, 0, 0);
    drive(1, 1, 8'h41, 0, 0);
    repeat (99) drive(1, 0, 8'h00, 0, 0);
    chk("to_before_lock", 64'(bus3.locked), 64'd1);
    chk("to_before_err", 64'(bus3.err_cnt), 64'd0);
    drive(1, 0, 8'h00, 0, 0);
`ifdef UART_STREAM_CHK_TIMEOUT_EN
    chk("to_fire_lock", 64'(bus3.locked), 64'd0);
    chk("to_fire_err", 64'(bus3.err_cnt), 64'd1);
    chk("to_fire_estb", 64'(bus3.err_strobe), 64'd1);
`else
    chk("to_off_lock", 64'(bus3.locked), 64'd1);
    chk("to_off_err", 64'(bus3.err_cnt), 64'd0);
`endif
    // strobe in the cycle the timeout would fire wins
    drive(0, 0, 8'h00, 0, 0);
    drive(1, 1, 8'h41, 0, 0);
    repeat (99) drive(1, 0, 8'h00, 0, 0);
    drive(1, 1, 8'h42, 0, 0);
    chk("to_race_lock", 64'(bus3.locked), 64'd1);
    chk("to_race_err", 64'(bus3.err_cnt), 64'd0);
    // reset while tracking restores every output
    drive(0, 1, 8'h43, 1, 1);
    chk("to_rst_outs",
        64'({bus3.locked, bus3.err_strobe, bus3.tx_load, bus3.cmd_busy,
             bus3.tx_data, bus3.frame_cnt, bus3.err_cnt}),
        64'({1'b0, 1'b0, 1'b0, 1'b0, 8'h53, 16'd0, 16'd0}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_stream_checker.md
# uart_stream_checker

Receive-side counterpart to the board's 8N1 byte-stream generator. Sits on the `DATA` / `DATA_RDY_STROBE` outputs of a `fast_8N1_UART_RX` instance and checks the incoming 32-byte frame pattern: 31 bytes `BASE + i`, then newline `0x0A`. It keeps saturating frame and error counters. It also drives a `fast_8N1_UART_TX` to send the single-byte toggle command `'S'` (`0x53`) on request, so a second board can start and stop the far-end generator.

## Interface
Parameters:
- `BASE`, default `8'h41`: first pattern byte. Byte `i` (0..30) of a frame is `BASE + i`, mod 256.
- `CNT_W`, default `16`: width of the frame and error counters.
- `TIMEOUT_CYCLES`, default `24000`: inter-byte timeout, in clocks (1 ms at 24 MHz). Used only with the timeout feature.

Ports:
- `sys_clk`  in  1  system clock (24 MHz HFOSC)
- `rst_n`  in  1  synchronous, active-low reset
- `rx_data`  in  8  received byte, valid when `rx_strobe` is high
- `rx_strobe`  in  1  one-cycle byte-valid strobe from the RX block
- `send_cmd`  in  1  one-cycle request to transmit `'S'`
- `load_ok`  in  1  TX ready flag
- `tx_load`  out  1  TX load pulse
- `tx_data`  out  8  TX byte
- `cmd_busy`  out  1  a command transmission is in progress
- `locked`  out  1  checker is tracking a frame
- `frame_cnt`  out  `CNT_W`  count of good frames, saturating
- `err_cnt`  out  `CNT_W`  count of errors, saturating
- `err_strobe`  out  1  one-cycle pulse per error

## Operation
- Checker FSM states:
  - HUNT: on a strobed byte equal to `BASE`, go to TRACK with `idx`=1. Any other byte is discarded, with no error.
  - TRACK: expected byte is `BASE + idx` for `idx` 0..30, and `0x0A` for `idx`=31.
  - Match at `idx`=31: `frame_cnt`++ and `idx`=0, staying in TRACK.
  - Match at any other `idx`: `idx`++.
  - Mismatch: `err_cnt`++, pulse `err_strobe`, go to HUNT. The mismatching byte is not re-examined as a frame start.
- `idx` is 5 bits wide and wraps 31→0 only via the frame-complete path.
- `locked` = 1 exactly when the state is TRACK.
- Both counters saturate at all-ones and never wrap.
- Command FSM:
  - C_IDLE: on `send_cmd`, go to C_WAIT.
  - C_WAIT: when `load_ok`=1, go to C_LOAD.
  - C_LOAD: drive `tx_load`=1 for exactly one cycle, then go to C_DRAIN.
  - C_DRAIN: when `load_ok`=0, go to C_IDLE.
- `cmd_busy` = 1 in every state except C_IDLE. `send_cmd` while busy is ignored and does not queue.
- `tx_data` is constant `8'h53`.
- The checker and command FSMs are fully independent; simultaneous events on both are all honoured.

## Timing
- Reset values: `tx_load`=0, `tx_data`=`8'h53`, `cmd_busy`=0, `locked`=0, `frame_cnt`=0, `err_cnt`=0, `err_strobe`=0. Both FSMs are in HUNT / C_IDLE.
- Reset asserted mid-frame or mid-command aborts immediately. No `tx_load` is issued after reset.
- All outputs are registered.
- A `rx_strobe` in cycle N updates `locked`, the counters and `err_strobe` in cycle N+1.
- Back-to-back strobes (every cycle) must be handled with no lost bytes.
- `send_cmd` in cycle N with `load_ok`=1 produces `tx_load`=1 in cycle N+2: one cycle in C_WAIT, then C_LOAD.
- C_DRAIN requires `load_ok` to fall before another load can be issued. This prevents a double send.

## Configuration
- Macro `UART_STREAM_CHK_TIMEOUT_EN`.
- Defined:
  - A `$clog2(TIMEOUT_CYCLES+1)`-bit idle counter runs in TRACK. It clears on every `rx_strobe`.
  - On reaching `TIMEOUT_CYCLES`: `err_cnt`++, pulse `err_strobe`, go to HUNT.
  - The counter is held at 0 in HUNT.
  - If a strobe arrives in the same cycle the timeout fires, the strobe wins and no timeout is counted.
- Undefined: no idle counter. TRACK persists indefinitely between bytes.

## Structure
- Package `uart_stream_pkg` holds:
  - constants `FRAME_LEN`=32, `NEWLINE`=`8'h0A`, `CMD_TOGGLE`=`8'h53`, `BASE_DEFAULT`=`8'h41`
  - the checker state typedef (HUNT, TRACK)
  - the command state typedef (C_IDLE, C_WAIT, C_LOAD, C_DRAIN)
- Sub-module `uart_cmd_sender` contains the command FSM. Its ports are `sys_clk`, `rst_n`, `send_cmd`, `load_ok`, `tx_load`, `tx_data` and `cmd_busy`.
- The checker FSM and counters stay in the top of this block.

## Test plan
- Reset, then two clean frames ("A".."_", `0x0A`, twice) → `locked`=1 after the first `0x41`, `frame_cnt`=2, `err_cnt`=0.
- Stream `0x41 0x42 0x58` → on `0x58`: `err_strobe` pulses once, `err_cnt`=1, `locked`=0. A following full frame gives `frame_cnt`=1.
- Leading junk `0x00 0x7F` before a frame → no errors, `frame_cnt`=1.
- Clean frames with `CNT_W`=2 → `frame_cnt` reaches 3 and stays at 3.
- `send_cmd` with `load_ok`=1:
  - `tx_load` pulses one cycle with `tx_data`=`0x53`.
  - A second `send_cmd` before `load_ok` falls is ignored.
  - Exactly one load is issued in total.
- With `UART_STREAM_CHK_TIMEOUT_EN`, `TIMEOUT_CYCLES`=100: send `0x41`, then idle 100 cycles → `err_cnt`=1 and `locked`=0. Reset asserted mid-frame → all outputs return to their reset values on the next edge.
